// File: rtl/prince_req_seq.sv
// rtl/prince_req_seq.sv - request sequencer for the round-based PRINCE core
// Latches one request, pulses st, tracks act with timeouts, buffers one result.
module prince_req_seq #(
   parameter int DW      = 64,
   parameter int KW      = 128,
   parameter int ACT_TMO = 4,
   parameter int RUN_TMO = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_pt,
   input  logic [KW-1:0] in_key,
   input  logic          in_dec,
   output logic          st,
   input  logic          act,
   output logic [DW-1:0] core_pt,
   output logic [KW-1:0] core_key,
   output logic          core_dec,
   input  logic [DW-1:0] core_ct,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_ct,
   output logic          busy,
   output logic          err,
   input  logic          clr_err
);

   localparam int TMO_MAX = (ACT_TMO > RUN_TMO) ? ACT_TMO : RUN_TMO;
   localparam int CW      = $clog2(TMO_MAX) + 1;
   localparam logic [CW-1:0] ACT_LIM = CW'(ACT_TMO);
   localparam logic [CW-1:0] RUN_LIM = CW'(RUN_TMO);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, START, WAIT_ACT, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            st_q, st_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_ct_q, out_ct_d;
   logic [DW-1:0]   core_pt_q, core_pt_d;
   logic [KW-1:0]   core_key_q, core_key_d;
   logic            core_dec_q, core_dec_d;
   logic            err_q, err_d;
   logic            tmo;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      st_d        = 1'b0;
      out_valid_d = out_valid_q;
      out_ct_d    = out_ct_q;
      core_pt_d   = core_pt_q;
      core_key_d  = core_key_q;
      core_dec_d  = core_dec_q;
      tmo         = 1'b0;
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               core_pt_d  = in_pt;
               core_key_d = in_key;
               core_dec_d = in_dec;
               st_d       = 1'b1;
               state_d    = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT_ACT;
         end
         WAIT_ACT: begin
            if (act) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= ACT_LIM) begin
                  tmo     = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         RUN: begin
            // act falling always captures, even on the would-be timeout cycle
            if (!act) begin
               out_ct_d    = core_ct;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= RUN_LIM) begin
                  tmo     = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      err_d = (tmo) ? 1'b1 : (clr_err ? 1'b0 : err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         st_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_ct_q    <= '0;
         core_pt_q   <= '0;
         core_key_q  <= '0;
         core_dec_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         st_q        <= st_d;
         out_valid_q <= out_valid_d;
         out_ct_q    <= out_ct_d;
         core_pt_q   <= core_pt_d;
         core_key_q  <= core_key_d;
         core_dec_q  <= core_dec_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign st        = st_q;
   assign out_valid = out_valid_q;
   assign out_ct    = out_ct_q;
   assign core_pt   = core_pt_q;
   assign core_key  = core_key_q;
   assign core_dec  = core_dec_q;
   assign err       = err_q;

endmodule

// File: tb/tb_prince_req_seq.sv
// tb/tb_prince_req_seq.sv - directed bench for prince_req_seq
// Table of request/act-length vectors plus hand sequences for error and reset cases.
module tb_prince_req_seq;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_pt;
   logic [127:0]  in_key;
   logic          in_dec;
   logic          st;
   logic          act;
   logic [63:0]   core_pt;
   logic [127:0]  core_key;
   logic          core_dec;
   logic [63:0]   core_ct;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_ct;
   logic          busy;
   logic          err;
   logic          clr_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   prince_req_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pt     (in_pt),
      .in_key    (in_key),
      .in_dec    (in_dec),
      .st        (st),
      .act       (act),
      .core_pt   (core_pt),
      .core_key  (core_key),
      .core_dec  (core_dec),
      .core_ct   (core_ct),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ct    (out_ct),
      .busy      (busy),
      .err       (err),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]  pt;
      logic [127:0] key;
      logic         dec;
      int           n;
      logic [63:0]  ct;
      logic         exp_err;
      int           exp_t;
      int           bp;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // t counts edges after the accept edge; outputs are observed 1 time unit after each edge
   task automatic run_row(input vec_t v);
      int   t;
      int   ev_t;
      logic seen;
      logic st_bad;
      chk("pre_in_ready", 128'(in_ready), 128'(1));
      in_valid = 1'b1;
      in_pt    = v.pt;
      in_key   = v.key;
      in_dec   = v.dec;
      act      = 1'b0;
      core_ct  = v.ct;
      tick();
      in_valid = 1'b0;
      in_pt    = ~v.pt;
      in_key   = ~v.key;
      in_dec   = ~v.dec;
      chk("st_after_accept", 128'(st), 128'(1));
      chk("core_pt", 128'(core_pt), 128'(v.pt));
      chk("core_key", v.key, core_key);
      chk("core_dec", 128'(core_dec), 128'(v.dec));
      chk("in_ready_busy", 128'(in_ready), 128'(0));
      chk("busy", 128'(busy), 128'(1));
      t = 0; ev_t = -1; seen = 1'b0; st_bad = 1'b0;
      while (!seen && t < 40) begin
         act     = (v.n > 0 && t >= 1 && t <= v.n);
         core_ct = act ? ~v.ct : v.ct;
         tick();
         t++;
         if (st) st_bad = 1'b1;
         if (out_valid || err) begin
            seen = 1'b1;
            ev_t = t;
         end
      end
      act = 1'b0;
      chk("event_time", 128'(ev_t), 128'(v.exp_t));
      chk("st_single_pulse", 128'(st_bad), 128'(0));
      chk("err_flag", 128'(err), 128'(v.exp_err));
      chk("core_pt_hold", 128'(core_pt), 128'(v.pt));
      if (v.exp_err) begin
         chk("no_out_valid_on_err", 128'(out_valid), 128'(0));
         chk("in_ready_after_err", 128'(in_ready), 128'(1));
         clr_err = 1'b1;
         tick();
         clr_err = 1'b0;
         chk("err_cleared", 128'(err), 128'(0));
      end else begin
         chk("out_valid", 128'(out_valid), 128'(1));
         chk("out_ct", 128'(out_ct), 128'(v.ct));
         out_ready = 1'b0;
         in_valid  = (v.bp > 0);
         for (int i = 0; i < v.bp; i++) begin
            core_ct = {$urandom, $urandom};
            tick();
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_ct", 128'(out_ct), 128'(v.ct));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("drain_out_valid", 128'(out_valid), 128'(0));
         chk("drain_in_ready", 128'(in_ready), 128'(1));
         chk("drain_no_accept", 128'(st), 128'(0));
         in_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic st_bad;
      int   t;
      int   ev_t;

      vecs[0] = '{64'h0, 128'h0, 1'b0, 12, 64'h818665aa0d02dfda, 1'b0, 14, 0};
      vecs[1] = '{64'h0123456789abcdef, 128'h00112233445566778899aabbccddeeff, 1'b0, 12,
                  64'hae25ad3ca8fa9ccf, 1'b0, 14, 10};
      vecs[2] = '{64'hfedcba9876543210, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 1,
                  64'h1122334455667788, 1'b0, 3, 0};
      vecs[3] = '{64'hffffffffffffffff, {128{1'b1}}, 1'b0, 16, 64'h9fb51935fc3df524, 1'b0, 18, 2};
      vecs[4] = '{64'h5555aaaa5555aaaa, 128'h1, 1'b1, 15, 64'hd6dcb5978de756ee, 1'b0, 17, 0};
      vecs[5] = '{64'h1234, 128'h5678, 1'b0, 0, 64'h0, 1'b1, 5, 0};
      vecs[6] = '{64'h9abc, 128'hdef0, 1'b1, 17, 64'h0, 1'b1, 18, 0};

      rst_n = 1'b0; in_valid = 1'b0; in_pt = '0; in_key = '0; in_dec = 1'b0;
      act = 1'b0; core_ct = '0; out_ready = 1'b0; clr_err = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_st", 128'(st), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_core_pt", 128'(core_pt), 128'(0));
      chk("rst_core_key", core_key, 128'(0));
      chk("rst_out_ct", 128'(out_ct), 128'(0));
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) run_row(vecs[i]);

      // clr_err coinciding with an act timeout: set must win
      in_valid = 1'b1; in_pt = 64'h77; act = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("collide_err_before", 128'(err), 128'(0));
      clr_err = 1'b1;
      tick();
      chk("collide_set_wins", 128'(err), 128'(1));
      tick();
      clr_err = 1'b0;
      chk("collide_then_clear", 128'(err), 128'(0));

      // stuck act for 40 cycles; second request accepted while act still high
      in_valid = 1'b1; in_pt = 64'haaaa; in_key = 128'hbbbb; in_dec = 1'b0;
      tick();
      in_valid = 1'b0;
      t = 0; ev_t = -1;
      while (ev_t < 0 && t < 40) begin
         act = (t >= 1 && t <= 40);
         tick();
         t++;
         if (err) ev_t = t;
      end
      chk("stuck_err_time", 128'(ev_t), 128'(18));
      chk("stuck_in_ready", 128'(in_ready), 128'(1));
      chk("stuck_no_out_valid", 128'(out_valid), 128'(0));
      in_valid = 1'b1; in_pt = 64'hcccc; in_key = 128'hdddd; in_dec = 1'b1; clr_err = 1'b1;
      act = 1'b1;
      tick();
      t++;
      in_valid = 1'b0; clr_err = 1'b0;
      chk("stuck_reaccept_st", 128'(st), 128'(1));
      chk("stuck_reaccept_pt", 128'(core_pt), 128'(64'hcccc));
      chk("stuck_reaccept_err_clr", 128'(err), 128'(0));
      ev_t = -1;
      while (ev_t < 0 && t < 60) begin
         act = (t <= 40);
         tick();
         t++;
         if (err) ev_t = t;
      end
      chk("stuck_second_err_time", 128'(ev_t), 128'(37));
      act = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("stuck_err_clear", 128'(err), 128'(0));

      // reset in the middle of RUN
      in_valid = 1'b1; in_pt = 64'hfeed; in_key = 128'hbeef; in_dec = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         act = (k >= 1);
         tick();
      end
      chk("pre_reset_busy", 128'(busy), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_st", 128'(st), 128'(0));
      chk("mid_rst_core_pt", 128'(core_pt), 128'(0));
      chk("mid_rst_core_key", core_key, 128'(0));
      chk("mid_rst_core_dec", 128'(core_dec), 128'(0));
      chk("mid_rst_out_ct", 128'(out_ct), 128'(0));
      act = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      st_bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (st || out_valid || err) st_bad = 1'b1;
      end
      chk("post_rst_quiet", 128'(st_bad), 128'(0));
      run_row(vecs[0]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
